muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit with HI/LO registers, sitting beside the single-cycle ALU in the datapath.
- Executes MIPS MULT/MULTU/DIV/DIVU over WIDTH bits in WIDTH+1 cycles, and services MFHI/MFLO/MTHI/MTLO.
- Raises a stall exception when the datapath touches HI/LO or issues a new op while an operation is in flight.
- Unlike the ALU, it holds state: HI, LO, an iteration counter and a three-state FSM.

---
 rtl/muldiv_unit_pkg.sv | 35 +++
 rtl/muldiv_unit_if.sv | 23 ++
 rtl/muldiv_unit.sv | 199 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared op codes and trap codes for the multiply/divide unit and its neighbours.
package muldiv_unit_pkg;

    // Operation codes presented on the 3-bit op bus of the MDU.
    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MFHI  = 3'd4,
        MDU_MFLO  = 3'd5,
        MDU_MTHI  = 3'd6,
        MDU_MTLO  = 3'd7
    } mduOp_e;

    // Stall trap code used by the datapath; the MDU reports its stall with the same value.
    localparam logic [7:0] TRAP_STALL = 8'h0C;
    localparam logic [7:0] EXC_STALL  = TRAP_STALL;

    // True for the four iterative operations that occupy the unit for many cycles.
    function automatic logic isArithOp(input mduOp_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // True for the operations that go through the restoring divider.
    function automatic logic isDivOp(input mduOp_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // True for the operations that treat their operands as two's complement.
    function automatic logic isSignedOp(input mduOp_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Operation bus between the datapath (master) and the multiply/divide unit (slave).
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic [WIDTH-1:0] out_val;
    logic             busy;
    logic [7:0]       exception;

    modport master (
        output op_valid, op, rs_val, rt_val, flush,
        input  out_val, busy, exception
    );

    modport slave (
        input  op_valid, op, rs_val, rt_val, flush,
        output out_val, busy, exception
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Magnitudes are processed one bit per cycle; signs are applied in a final FIXUP cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FIXUP = 2'd2
    } state_e;

    state_e             r_state;
    state_e             w_nextState;

    logic [2*WIDTH-1:0] r_accum;
    logic [WIDTH-1:0]   r_opnd;
    logic [CW-1:0]      r_count;
    logic               r_isDiv;
    logic               r_negQ;
    logic               r_negRem;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    mduOp_e             w_op;
    logic               w_accept;
    logic               w_start;
    logic               w_opIsDiv;
    logic               w_divZero;
    logic               w_rsNeg;
    logic               w_rtNeg;
    logic [WIDTH-1:0]   w_rsAbs;
    logic [WIDTH-1:0]   w_rtAbs;

    logic [WIDTH:0]     w_mulSum;
    logic [2*WIDTH-1:0] w_mulStep;
    logic [WIDTH:0]     w_divPart;
    logic [WIDTH:0]     w_divDiff;
    logic [2*WIDTH-1:0] w_divStep;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fixHi;
    logic [WIDTH-1:0]   w_fixLo;

    // Decode the presented op and condition operands for the iterative datapath.
    always_comb begin
        w_op      = mduOp_e'(bus.op);
        w_accept  = bus.op_valid && (r_state == S_IDLE) && !bus.flush && !rst;
        w_start   = w_accept && isArithOp(w_op);
        w_opIsDiv = isDivOp(w_op);
        w_divZero = w_opIsDiv && (bus.rt_val == '0);
        w_rsNeg   = isSignedOp(w_op) && bus.rs_val[WIDTH-1];
        w_rtNeg   = isSignedOp(w_op) && bus.rt_val[WIDTH-1];
        w_rsAbs   = w_rsNeg ? (-bus.rs_val) : bus.rs_val;
        w_rtAbs   = w_rtNeg ? (-bus.rt_val) : bus.rt_val;
    end

    // One iteration of shift-add multiply and restoring divide, plus the sign fixup of the result.
    always_comb begin
        // Multiply: upper half accumulates the multiplicand, multiplier bits leave from the bottom.
        w_mulSum  = {1'b0, r_accum[2*WIDTH-1:WIDTH]} + (r_accum[0] ? {1'b0, r_opnd} : '0);
        w_mulStep = {w_mulSum, r_accum[WIDTH-1:1]};

        // Divide: partial remainder shifted left with the next dividend bit, quotient bits enter at the bottom.
        w_divPart = r_accum[2*WIDTH-1:WIDTH-1];
        w_divDiff = w_divPart - {1'b0, r_opnd};
        if (w_divDiff[WIDTH]) begin
            w_divStep = {w_divPart[WIDTH-1:0], r_accum[WIDTH-2:0], 1'b0};
        end else begin
            w_divStep = {w_divDiff[WIDTH-1:0], r_accum[WIDTH-2:0], 1'b1};
        end

        w_product = r_negQ ? (-r_accum) : r_accum;
        w_quot    = r_negQ ? (-r_accum[WIDTH-1:0]) : r_accum[WIDTH-1:0];
        w_rem     = r_negRem ? (-r_accum[2*WIDTH-1:WIDTH]) : r_accum[2*WIDTH-1:WIDTH];
        w_fixHi   = r_isDiv ? w_rem  : w_product[2*WIDTH-1:WIDTH];
        w_fixLo   = r_isDiv ? w_quot : w_product[WIDTH-1:0];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state logic; flush abandons whatever is in flight.
    always_comb begin
        w_nextState = r_state;
        if (bus.flush) begin
            w_nextState = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        w_nextState = (w_opIsDiv && w_divZero) ? S_FIXUP : S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_count == '0) begin
                        w_nextState = S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    w_nextState = S_IDLE;
                end
                default: begin
                    w_nextState = S_IDLE;
                end
            endcase
        end
    end

    // Datapath and HI/LO registers: load on accept, iterate in RUN, commit in FIXUP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_accum  <= '0;
            r_opnd   <= '0;
            r_count  <= '0;
            r_isDiv  <= 1'b0;
            r_negQ   <= 1'b0;
            r_negRem <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_isDiv <= w_opIsDiv;
                        r_count <= CW'(WIDTH - 1);
                        if (w_opIsDiv && w_divZero) begin
                            // Preloading the raw result lets FIXUP commit it unchanged.
                            r_accum  <= {bus.rs_val, {WIDTH{1'b1}}};
                            r_opnd   <= bus.rt_val;
                            r_negQ   <= 1'b0;
                            r_negRem <= 1'b0;
                        end else if (w_opIsDiv) begin
                            r_accum  <= {{WIDTH{1'b0}}, w_rsAbs};
                            r_opnd   <= w_rtAbs;
                            r_negQ   <= w_rsNeg ^ w_rtNeg;
                            r_negRem <= w_rsNeg;
                        end else begin
                            r_accum  <= {{WIDTH{1'b0}}, w_rtAbs};
                            r_opnd   <= w_rsAbs;
                            r_negQ   <= w_rsNeg ^ w_rtNeg;
                            r_negRem <= 1'b0;
                        end
                    end
                    if (w_accept && (w_op == MDU_MTHI)) begin
                        r_hi <= bus.rs_val;
                    end
                    if (w_accept && (w_op == MDU_MTLO)) begin
                        r_lo <= bus.rs_val;
                    end
                end
                S_RUN: begin
                    if (!bus.flush) begin
                        r_accum <= r_isDiv ? w_divStep : w_mulStep;
                        if (r_count != '0) begin
                            r_count <= r_count - CW'(1);
                        end
                    end
                end
                S_FIXUP: begin
                    if (!bus.flush) begin
                        r_hi <= w_fixHi;
                        r_lo <= w_fixLo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: busy flag, stall exception, and the MFHI/MFLO read port.
    always_comb begin
        bus.busy      = (r_state != S_IDLE);
        bus.exception = (bus.op_valid && (r_state != S_IDLE)) ? EXC_STALL : 8'h00;
        bus.out_val   = '0;
        if (w_accept && (w_op == MDU_MFHI)) begin
            bus.out_val = r_hi;
        end else if (w_accept && (w_op == MDU_MFLO)) begin
            bus.out_val = r_lo;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table for the arithmetic ops plus
// hand-written sequences for stall, flush, reset and back-to-back issue.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int W = 32;

    typedef struct {
        string       name;
        mduOp_e      op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expBusy;
    } vec_t;

    logic clk;
    logic rst;
    int   cmpCount;
    int   failCount;
    vec_t vecs [13];

    muldiv_unit_if #(.WIDTH(W)) mdu ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mdu)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a stuck DUT can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        cmpCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present an op for one cycle; returns at the negedge after the accepting edge.
    task automatic issueOp(input mduOp_e op, input logic [31:0] rs, input logic [31:0] rt);
        mdu.op_valid = 1'b1;
        mdu.op       = op;
        mdu.rs_val   = rs;
        mdu.rt_val   = rt;
        @(negedge clk);
        mdu.op_valid = 1'b0;
    endtask

    // Count busy cycles (sampled at negedges) until the unit is idle, bounded.
    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (mdu.busy && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    // Read HI and LO through MFHI/MFLO within the current low clock phase.
    task automatic readHiLo(output logic [31:0] hi, output logic [31:0] lo);
        mdu.op_valid = 1'b1;
        mdu.op       = MDU_MFHI;
        #1;
        hi = mdu.out_val;
        mdu.op       = MDU_MFLO;
        #1;
        lo = mdu.out_val;
        mdu.op_valid = 1'b0;
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
        issueOp(v.op, v.rs, v.rt);
        waitIdle(cycles);
        checkOutput({v.name, " busy cycles"}, 64'(cycles), 64'(v.expBusy));
        readHiLo(hi, lo);
        checkOutput({v.name, " HI"}, 64'(hi), 64'(v.expHi));
        checkOutput({v.name, " LO"}, 64'(lo), 64'(v.expLo));
    endtask

    initial begin
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;

        cmpCount  = 0;
        failCount = 0;

        vecs[0]  = '{"MULT -3*5",        MDU_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 33};
        vecs[1]  = '{"MULTU max*max",    MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
        vecs[2]  = '{"DIVU 100/7",       MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33};
        vecs[3]  = '{"DIV -7/2",         MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[4]  = '{"DIV 7/0",          MDU_DIV,   32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1};
        vecs[5]  = '{"MULT min*min",     MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
        vecs[6]  = '{"DIV min/-1",       MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[7]  = '{"DIV -8/-3",        MDU_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 33};
        vecs[8]  = '{"MULTU 2^16*2^16",  MDU_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 33};
        vecs[9]  = '{"DIVU max/16",      MDU_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 33};
        vecs[10] = '{"MULT 7*-2",        MDU_MULT,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 33};
        vecs[11] = '{"DIV 7/-2",         MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
        vecs[12] = '{"DIV -7/0",         MDU_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1};

        mdu.op_valid = 1'b0;
        mdu.op       = MDU_MULT;
        mdu.rs_val   = '0;
        mdu.rt_val   = '0;
        mdu.flush    = 1'b0;
        rst          = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("reset busy",      64'(mdu.busy),      64'd0);
        checkOutput("reset exception", 64'(mdu.exception), 64'd0);
        checkOutput("reset out_val",   64'(mdu.out_val),   64'd0);
        rst = 1'b0;
        @(negedge clk);
        readHiLo(hi, lo);
        checkOutput("reset HI", 64'(hi), 64'd0);
        checkOutput("reset LO", 64'(lo), 64'd0);

        // Arithmetic vector table.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
        end

        // Stall: MFLO on cycle 5 of a MULT is rejected, then re-read after completion.
        issueOp(MDU_MULT, 32'd6, 32'd7);
        repeat (4) @(negedge clk);
        mdu.op_valid = 1'b1;
        mdu.op       = MDU_MFLO;
        #1;
        checkOutput("stall exception", 64'(mdu.exception), 64'(EXC_STALL));
        checkOutput("stall out_val",   64'(mdu.out_val),   64'd0);
        mdu.op_valid = 1'b0;
        #1;
        checkOutput("stall exception clears", 64'(mdu.exception), 64'd0);
        waitIdle(cycles);
        checkOutput("stall total busy", 64'(cycles + 4), 64'd33);
        readHiLo(hi, lo);
        checkOutput("stall reissue LO", 64'(lo), 64'd42);
        checkOutput("stall reissue HI", 64'(hi), 64'd0);
        @(negedge clk);

        // Flush on cycle 10 of a DIV leaves HI/LO as written by MTHI/MTLO.
        issueOp(MDU_MTHI, 32'h00001234, 32'd0);
        issueOp(MDU_MTLO, 32'h00005678, 32'd0);
        issueOp(MDU_DIV, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        checkOutput("flush pre busy", 64'(mdu.busy), 64'd1);
        mdu.flush = 1'b1;
        @(negedge clk);
        mdu.flush = 1'b0;
        checkOutput("flush busy", 64'(mdu.busy), 64'd0);
        readHiLo(hi, lo);
        checkOutput("flush HI", 64'(hi), 64'h1234);
        checkOutput("flush LO", 64'(lo), 64'h5678);
        @(negedge clk);

        // Flush together with op_valid: nothing is accepted.
        mdu.flush = 1'b1;
        issueOp(MDU_MULT, 32'd3, 32'd3);
        mdu.flush = 1'b0;
        checkOutput("flush+op busy", 64'(mdu.busy), 64'd0);
        readHiLo(hi, lo);
        checkOutput("flush+op HI", 64'(hi), 64'h1234);
        checkOutput("flush+op LO", 64'(lo), 64'h5678);
        @(negedge clk);

        // Reset on cycle 20 of a MULTU clears HI/LO; a new MULT is accepted right after.
        issueOp(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst busy", 64'(mdu.busy), 64'd0);
        readHiLo(hi, lo);
        checkOutput("rst HI", 64'(hi), 64'd0);
        checkOutput("rst LO", 64'(lo), 64'd0);
        issueOp(MDU_MULT, 32'hFFFFFFFD, 32'd5);
        checkOutput("post-rst accept busy", 64'(mdu.busy), 64'd1);
        waitIdle(cycles);
        checkOutput("post-rst busy cycles", 64'(cycles), 64'd33);
        readHiLo(hi, lo);
        checkOutput("post-rst HI", 64'(hi), 64'hFFFFFFFF);
        checkOutput("post-rst LO", 64'(lo), 64'hFFFFFFF1);
        @(negedge clk);

        // Back-to-back: the next op is accepted in the first cycle busy is low.
        issueOp(MDU_MULTU, 32'd3, 32'd4);
        waitIdle(cycles);
        checkOutput("b2b first busy cycles", 64'(cycles), 64'd33);
        issueOp(MDU_DIVU, 32'd100, 32'd7);
        checkOutput("b2b second accept busy", 64'(mdu.busy), 64'd1);
        waitIdle(cycles);
        checkOutput("b2b second busy cycles", 64'(cycles), 64'd33);
        readHiLo(hi, lo);
        checkOutput("b2b HI", 64'(hi), 64'd2);
        checkOutput("b2b LO", 64'(lo), 64'd14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
        $finish;
    end

endmodule
